mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline interface in the 16-bit pipelined CPU.
- Takes the registered EX/MEM outputs and performs the data-memory access over a req/ack handshake to a variable-latency data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Produces the registered MEM/WB writeback bundle (data, address, enable).

Parameters:
- DW, 16: data and address width.
- RW, 4: register-file write-address width.
- TIMEOUT, 15: max cycles in REQ without ack before the access is aborted.
- CW, 4: timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dmem_wen_exmem  in  1  store instruction.
- mem2reg_exmem  in  1  load instruction (writeback from memory).
- rf_wen_exmem  in  1  register-file write enable.
- rf_waddr_exmem  in  RW  destination register.
- aluout_exmem  in  DW  ALU result / memory address.
- rdata2_exmem  in  DW  store data.
- pc_added_exmem  in  DW  PC+1 for link.
- jal_exmem  in  1  jump-and-link (writeback pc_added).
- nop_lw_exmem  in  1  load squashed to bubble.
- nop_sw_exmem  in  1  store squashed to bubble.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=write, 0=read.
- dmem_addr  out  DW  memory address.
- dmem_wdata  out  DW  write data.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  DW  read data, valid with dmem_ack.
- mem_stall  out  1  hold EX/MEM and all earlier stages.
- mem_err  out  1  one-cycle pulse on timeout abort.
- rf_wen_memwb  out  1  writeback enable.
- rf_waddr_memwb  out  RW  writeback register.
- wb_data_memwb  out  DW  writeback data.

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, rf_wen_memwb, rf_waddr_memwb, wb_data_memwb). FSM goes to IDLE; counter clears. Reset during REQ drops dmem_req immediately and discards the access.
- Operation decode:
  - ld = mem2reg_exmem & ~nop_lw_exmem
  - st = dmem_wen_exmem & ~nop_sw_exmem
  - memop = ld | st
- FSM states: IDLE, REQ.
- IDLE, memop=0:
  - mem_stall=0.
  - Next edge registers rf_wen_memwb = rf_wen_exmem & ~nop_lw_exmem, rf_waddr_memwb = rf_waddr_exmem, and wb_data_memwb = jal_exmem ? pc_added_exmem : aluout_exmem.
- IDLE, memop=1:
  - mem_stall=1.
  - Next edge: dmem_req<=1, dmem_we<=st, dmem_addr<=aluout_exmem, dmem_wdata<=rdata2_exmem, counter<=0, rf_wen_memwb<=0, state<=REQ.
  - If ld and st are both 1, the store has priority and there is no writeback.
- REQ, dmem_ack=0:
  - mem_stall=1; counter increments; rf_wen_memwb held at 0.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
- REQ, dmem_ack=1:
  - mem_stall=0, so upstream advances on this edge.
  - Next edge: dmem_req<=0, state<=IDLE.
  - Load: rf_wen_memwb<=rf_wen_exmem, rf_waddr_memwb<=rf_waddr_exmem, wb_data_memwb<=dmem_rdata.
  - Store: rf_wen_memwb<=0.
- REQ, counter==TIMEOUT with no ack:
  - mem_stall=0.
  - Next edge: dmem_req<=0, mem_err<=1 for exactly one cycle, rf_wen_memwb<=0, wb_data_memwb<=0, state<=IDLE.
  - If ack and timeout coincide, ack wins and mem_err stays 0.
- dmem_ack seen while in IDLE is ignored.
- Latency: non-memory instruction 1 cycle; memory instruction minimum 2 cycles (1 issue + ack on the first REQ cycle). Back-to-back memory ops re-enter REQ after one IDLE cycle.
- dmem_addr and dmem_wdata keep their last values after completion; they are only meaningful while dmem_req=1.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, REQ=1'b1) and constants DW=16, RW=4.
- No sub-module. FSM, timeout counter and MEM/WB output registers live in one module.

Test Plan:
- ALU op: aluout=16'h0042, rf_waddr=4'h3, rf_wen=1, no memop -> mem_stall stays 0; next cycle rf_wen_memwb=1, waddr=3, wb_data=16'h0042.
- JAL: jal=1, pc_added=16'h0101, waddr=4'hF -> next cycle wb_data=16'h0101, rf_wen_memwb=1.
- Load, ack after 3 REQ cycles, rdata=16'hBEEF, addr=16'h0010, waddr=4'h5 -> dmem_req high 3 cycles with dmem_we=0 and dmem_addr=16'h0010; mem_stall high 3 cycles; then rf_wen_memwb=1, wb_data=16'hBEEF.
- Store addr=16'h0020, data=16'h1234, immediate ack -> dmem_we=1, dmem_wdata=16'h1234 for 1 cycle; rf_wen_memwb=0; 2-cycle total stall window then advance.
- No ack for TIMEOUT=15 cycles -> after 15 cycles dmem_req=0, one-cycle mem_err=1, rf_wen_memwb=0, state IDLE; then repeat with ack on cycle 15 -> mem_err=0 and data written back.
- nop_lw=1 with mem2reg=1 -> no dmem_req, rf_wen_memwb=0. Assert rst mid-REQ -> dmem_req=0 asynchronously, all outputs 0, and the next instruction after rst release issues normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths and FSM encoding for the MEM stage
package mem_access_stage_pkg;
    localparam int DW = 16;
    localparam int RW = 4;
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;
endpackage

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM consumer doing the data-memory req/ack access and producing MEM/WB
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DW      = mem_access_stage_pkg::DW,
    parameter int RW      = mem_access_stage_pkg::RW,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dmem_wen_exmem,
    input  logic          mem2reg_exmem,
    input  logic          rf_wen_exmem,
    input  logic [RW-1:0] rf_waddr_exmem,
    input  logic [DW-1:0] aluout_exmem,
    input  logic [DW-1:0] rdata2_exmem,
    input  logic [DW-1:0] pc_added_exmem,
    input  logic          jal_exmem,
    input  logic          nop_lw_exmem,
    input  logic          nop_sw_exmem,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          mem_stall,
    output logic          mem_err,
    output logic          rf_wen_memwb,
    output logic [RW-1:0] rf_waddr_memwb,
    output logic [DW-1:0] wb_data_memwb
);
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          ld, st, memop, tmo;

    assign ld    = mem2reg_exmem & ~nop_lw_exmem;
    assign st    = dmem_wen_exmem & ~nop_sw_exmem;
    assign memop = ld | st;
    assign tmo   = cnt == CW'(TIMEOUT);

    // state register; reset abandons any outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // issue on a memory op, return to IDLE on ack or timeout
    always_comb begin
        state_n = (state == IDLE) ? (memop ? REQ : IDLE) : ((dmem_ack | tmo) ? IDLE : REQ);
    end

    // stall upstream on issue and while the access is still pending
    always_comb begin
        mem_stall = (state == IDLE) ? memop : ~(dmem_ack | tmo);
    end

    // memory request, timeout counter and MEM/WB writeback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            mem_err        <= 1'b0;
            cnt            <= '0;
            rf_wen_memwb   <= 1'b0;
            rf_waddr_memwb <= '0;
            wb_data_memwb  <= '0;
        end else begin
            mem_err <= 1'b0;
            if (state == IDLE) begin
                if (memop) begin
                    dmem_req     <= 1'b1;
                    dmem_we      <= st;
                    dmem_addr    <= aluout_exmem;
                    dmem_wdata   <= rdata2_exmem;
                    cnt          <= '0;
                    rf_wen_memwb <= 1'b0;
                end else begin
                    rf_wen_memwb   <= rf_wen_exmem & ~nop_lw_exmem;
                    rf_waddr_memwb <= rf_waddr_exmem;
                    wb_data_memwb  <= jal_exmem ? pc_added_exmem : aluout_exmem;
                end
            end else if (dmem_ack) begin
                dmem_req     <= 1'b0;
                rf_wen_memwb <= rf_wen_exmem & ~dmem_we;
                if (!dmem_we) begin
                    rf_waddr_memwb <= rf_waddr_exmem;
                    wb_data_memwb  <= dmem_rdata;
                end
            end else if (tmo) begin
                dmem_req      <= 1'b0;
                mem_err       <= 1'b1;
                rf_wen_memwb  <= 1'b0;
                wb_data_memwb <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
